// File: rtl/ysyx_25020047_lsu.sv
// Multi-cycle load/store unit: one operation in flight, a word-aligned request on
// a valid/ready data bus, and load extraction toward write-back.
module ysyx_25020047_lsu #(
  parameter int unsigned RESP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_memdata,
  output logic [1:0]  out_fault
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // With the timeout disabled the counter still needs a ceiling so it never wraps.
  localparam logic [31:0] CNT_MAX = (RESP_TIMEOUT == 0) ? 32'hFFFF_FFFF : RESP_TIMEOUT;

  state_t      state_q, state_d;
  logic [3:0]  op_q;
  logic [1:0]  off_q;
  logic        req_wen_q;
  logic [31:0] req_addr_q;
  logic [31:0] req_wdata_q;
  logic [3:0]  req_wmask_q;
  logic [31:0] memdata_q;
  logic [1:0]  fault_q;
  logic [31:0] cnt_q;

  logic        acc_none;
  logic        acc_mis;
  logic        acc_wen;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_wmask;
  logic [31:0] rd_shift;
  logic [31:0] load_data;
  logic [31:0] cnt_inc;
  logic        timed_out;

  // Decode the incoming operation into bus lanes and alignment checks.
  always_comb begin
    acc_none  = 1'b1;
    acc_mis   = 1'b0;
    acc_wen   = 1'b0;
    acc_wdata = '0;
    acc_wmask = '0;
    case (in_op)
      4'd1, 4'd4: acc_none = 1'b0;
      4'd2, 4'd5: begin
        acc_none = 1'b0;
        acc_mis  = in_addr[0];
      end
      4'd3: begin
        acc_none = 1'b0;
        acc_mis  = |in_addr[1:0];
      end
      4'd9: begin
        acc_none  = 1'b0;
        acc_wen   = 1'b1;
        acc_wdata = {4{in_wdata[7:0]}};
        acc_wmask = 4'b0001 << in_addr[1:0];
      end
      4'd10: begin
        acc_none  = 1'b0;
        acc_mis   = in_addr[0];
        acc_wen   = 1'b1;
        acc_wdata = {2{in_wdata[15:0]}};
        acc_wmask = 4'b0011 << in_addr[1:0];
      end
      4'd11: begin
        acc_none  = 1'b0;
        acc_mis   = |in_addr[1:0];
        acc_wen   = 1'b1;
        acc_wdata = in_wdata;
        acc_wmask = 4'b1111;
      end
      default: ;
    endcase
  end

  // Select the addressed byte/halfword from the read word and extend it.
  always_comb begin
    rd_shift  = mem_resp_rdata >> {off_q, 3'b000};
    load_data = '0;
    case (op_q)
      4'd1:    load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      4'd2:    load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      4'd3:    load_data = rd_shift;
      4'd4:    load_data = {24'd0, rd_shift[7:0]};
      4'd5:    load_data = {16'd0, rd_shift[15:0]};
      default: load_data = '0;
    endcase
  end

  // Saturating wait counter and timeout detection.
  always_comb begin
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 32'd1;
    timed_out = (RESP_TIMEOUT != 0) && (cnt_inc == CNT_MAX);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a response beats a timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = (acc_mis || acc_none) ? DONE : REQ;
      REQ:  if (mem_req_ready) state_d = WAIT;
      WAIT: if (mem_resp_valid || timed_out) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latched operation fields, result, fault and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      off_q       <= '0;
      req_wen_q   <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wmask_q <= '0;
      memdata_q   <= '0;
      fault_q     <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          op_q        <= acc_none ? 4'd0 : in_op;
          off_q       <= in_addr[1:0];
          req_wen_q   <= acc_wen;
          req_addr_q  <= {in_addr[31:2], 2'b00};
          req_wdata_q <= acc_wdata;
          req_wmask_q <= acc_wmask;
          memdata_q   <= '0;
          fault_q     <= {1'b0, acc_mis};
        end
        WAIT: begin
          cnt_q <= cnt_inc;
          if (mem_resp_valid) memdata_q <= load_data;
          else if (timed_out) fault_q <= 2'b10;
        end
        DONE: if (out_ready) cnt_q <= '0;
        default: ;
      endcase
    end
  end

  // Output drive.
  always_comb begin
    in_ready      = (state_q == IDLE);
    mem_req_valid = (state_q == REQ);
    mem_req_wen   = req_wen_q;
    mem_req_addr  = req_addr_q;
    mem_req_wdata = req_wdata_q;
    mem_req_wmask = req_wmask_q;
    out_valid     = (state_q == DONE);
    out_memdata   = memdata_q;
    out_fault     = fault_q;
  end

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Directed testbench for ysyx_25020047_lsu.
module tb_ysyx_25020047_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_memdata;
  logic [1:0]  out_fault;

  int n_cmp = 0;
  int n_bad = 0;

  // Operation result captured by do_op.
  int          r_lat;
  bit          r_req;
  logic        r_wen;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wmask;

  ysyx_25020047_lsu #(.RESP_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_addr(in_addr), .in_wdata(in_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_memdata(out_memdata), .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  // Present one operation (entered and left at 1 time unit after a rising edge),
  // act as the bus (one-cycle response after request acceptance when respond=1)
  // and count edges from the accept edge until out_valid, bounded at 40 cycles.
  task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit respond, input logic [31:0] rdata);
    bit do_resp = 0;
    int k = 0;
    r_req = 0; r_wen = 0; r_addr = '0; r_wdata = '0; r_wmask = '0;
    in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wdata;
    @(posedge clk); #1;
    in_valid = 1'b0;
    r_lat = 1;
    while (!out_valid && k < 40) begin
      if (mem_req_valid) begin
        r_req = 1; r_wen = mem_req_wen; r_addr = mem_req_addr;
        r_wdata = mem_req_wdata; r_wmask = mem_req_wmask;
        do_resp = respond;
      end
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      if (do_resp) begin
        mem_resp_valid = 1'b1; mem_resp_rdata = rdata; do_resp = 0;
      end
      r_lat++; k++;
    end
    mem_resp_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (in_ready !== 1'b1) begin $display("FAIL rst_in_ready: got %b want 1", in_ready); n_bad++; end
    n_cmp++; if (mem_req_valid !== 1'b0) begin $display("FAIL rst_req_valid: got %b want 0", mem_req_valid); n_bad++; end
    n_cmp++; if (mem_req_wen !== 1'b0) begin $display("FAIL rst_wen: got %b want 0", mem_req_wen); n_bad++; end
    n_cmp++; if (mem_req_addr !== 32'h0) begin $display("FAIL rst_addr: got %h want 0", mem_req_addr); n_bad++; end
    n_cmp++; if (mem_req_wdata !== 32'h0) begin $display("FAIL rst_wdata: got %h want 0", mem_req_wdata); n_bad++; end
    n_cmp++; if (mem_req_wmask !== 4'h0) begin $display("FAIL rst_wmask: got %h want 0", mem_req_wmask); n_bad++; end
    n_cmp++; if (out_valid !== 1'b0) begin $display("FAIL rst_out_valid: got %b want 0", out_valid); n_bad++; end
    n_cmp++; if (out_memdata !== 32'h0) begin $display("FAIL rst_memdata: got %h want 0", out_memdata); n_bad++; end
    n_cmp++; if (out_fault !== 2'b00) begin $display("FAIL rst_fault: got %b want 00", out_fault); n_bad++; end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    do_op(4'd3, 32'h8000_0010, 32'h0, 1, 32'hDEAD_BEEF);
    n_cmp++; if (r_lat !== 3) begin $display("FAIL lw_latency: got %0d want 3", r_lat); n_bad++; end
    n_cmp++; if (r_addr !== 32'h8000_0010) begin $display("FAIL lw_req_addr: got %h want 80000010", r_addr); n_bad++; end
    n_cmp++; if (r_wmask !== 4'h0 || r_wen !== 1'b0) begin $display("FAIL lw_wmask_wen: got %h/%b want 0/0", r_wmask, r_wen); n_bad++; end
    n_cmp++; if (out_memdata !== 32'hDEAD_BEEF) begin $display("FAIL lw_memdata: got %h want deadbeef", out_memdata); n_bad++; end
    n_cmp++; if (out_fault !== 2'b00) begin $display("FAIL lw_fault: got %b want 00", out_fault); n_bad++; end
    n_cmp++; if (in_ready !== 1'b0) begin $display("FAIL lw_busy_in_ready: got %b want 0", in_ready); n_bad++; end
    // result must hold while write-back stalls
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1 || out_memdata !== 32'hDEAD_BEEF) begin
      $display("FAIL lw_hold: got valid=%b data=%h want 1/deadbeef", out_valid, out_memdata); n_bad++; end
    consume();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL lw_release: got valid=%b ready=%b want 0/1", out_valid, in_ready); n_bad++; end
  endtask

  task automatic test_byte_loads();
    do_op(4'd1, 32'h8000_0003, 32'h0, 1, 32'h80FF_1234);
    n_cmp++; if (out_memdata !== 32'hFFFF_FF80) begin $display("FAIL lb_off3: got %h want ffffff80", out_memdata); n_bad++; end
    n_cmp++; if (r_addr !== 32'h8000_0000) begin $display("FAIL lb_req_addr: got %h want 80000000", r_addr); n_bad++; end
    consume();
    do_op(4'd4, 32'h8000_0003, 32'h0, 1, 32'h80FF_1234);
    n_cmp++; if (out_memdata !== 32'h0000_0080) begin $display("FAIL lbu_off3: got %h want 00000080", out_memdata); n_bad++; end
    consume();
    do_op(4'd1, 32'h8000_0000, 32'h0, 1, 32'h80FF_1234);
    n_cmp++; if (out_memdata !== 32'h0000_0034) begin $display("FAIL lb_off0: got %h want 00000034", out_memdata); n_bad++; end
    consume();
    do_op(4'd2, 32'h8000_0002, 32'h0, 1, 32'h80FF_1234);
    n_cmp++; if (out_memdata !== 32'hFFFF_80FF) begin $display("FAIL lh_off2: got %h want ffff80ff", out_memdata); n_bad++; end
    n_cmp++; if (r_req !== 1'b1 || out_fault !== 2'b00) begin $display("FAIL lh_aligned: got req=%b fault=%b want 1/00", r_req, out_fault); n_bad++; end
    consume();
    do_op(4'd5, 32'h8000_0002, 32'h0, 1, 32'h80FF_1234);
    n_cmp++; if (out_memdata !== 32'h0000_80FF) begin $display("FAIL lhu_off2: got %h want 000080ff", out_memdata); n_bad++; end
    consume();
  endtask

  task automatic test_stores();
    do_op(4'd10, 32'h8000_0002, 32'h0000_ABCD, 1, 32'h1234_5678);
    n_cmp++; if (r_wdata !== 32'hABCD_ABCD) begin $display("FAIL sh_wdata: got %h want abcdabcd", r_wdata); n_bad++; end
    n_cmp++; if (r_wmask !== 4'b1100 || r_wen !== 1'b1) begin $display("FAIL sh_wmask_wen: got %b/%b want 1100/1", r_wmask, r_wen); n_bad++; end
    n_cmp++; if (out_memdata !== 32'h0 || out_fault !== 2'b00) begin $display("FAIL sh_result: got %h/%b want 0/00", out_memdata, out_fault); n_bad++; end
    consume();
    do_op(4'd9, 32'h8000_0001, 32'h1234_5678, 1, 32'hFFFF_FFFF);
    n_cmp++; if (r_wdata !== 32'h7878_7878 || r_wmask !== 4'b0010) begin $display("FAIL sb_lanes: got %h/%b want 78787878/0010", r_wdata, r_wmask); n_bad++; end
    n_cmp++; if (r_addr !== 32'h8000_0000) begin $display("FAIL sb_req_addr: got %h want 80000000", r_addr); n_bad++; end
    consume();
    do_op(4'd11, 32'h8000_0008, 32'hCAFE_F00D, 1, 32'hFFFF_FFFF);
    n_cmp++; if (r_wdata !== 32'hCAFE_F00D || r_wmask !== 4'b1111) begin $display("FAIL sw_lanes: got %h/%b want cafef00d/1111", r_wdata, r_wmask); n_bad++; end
    n_cmp++; if (r_lat !== 3 || out_memdata !== 32'h0) begin $display("FAIL sw_result: got lat=%0d data=%h want 3/0", r_lat, out_memdata); n_bad++; end
    consume();
  endtask

  task automatic test_misaligned_none();
    do_op(4'd3, 32'h8000_0001, 32'h0, 1, 32'h1111_1111);
    n_cmp++; if (r_lat !== 1) begin $display("FAIL mis_lw_latency: got %0d want 1", r_lat); n_bad++; end
    n_cmp++; if (r_req !== 1'b0) begin $display("FAIL mis_lw_no_req: got %b want 0", r_req); n_bad++; end
    n_cmp++; if (out_fault !== 2'b01 || out_memdata !== 32'h0) begin $display("FAIL mis_lw_fault: got %b/%h want 01/0", out_fault, out_memdata); n_bad++; end
    consume();
    do_op(4'd10, 32'h8000_0003, 32'h1234, 1, 32'h0);
    n_cmp++; if (out_fault !== 2'b01 || r_req !== 1'b0) begin $display("FAIL mis_sh: got fault=%b req=%b want 01/0", out_fault, r_req); n_bad++; end
    consume();
    do_op(4'd0, 32'h8000_0000, 32'h0, 1, 32'h2222_2222);
    n_cmp++; if (r_lat !== 1 || r_req !== 1'b0 || out_fault !== 2'b00 || out_memdata !== 32'h0) begin
      $display("FAIL none_op: got lat=%0d req=%b fault=%b data=%h want 1/0/00/0", r_lat, r_req, out_fault, out_memdata); n_bad++; end
    consume();
    do_op(4'd7, 32'h8000_0001, 32'h0, 1, 32'h2222_2222);
    n_cmp++; if (r_lat !== 1 || r_req !== 1'b0 || out_fault !== 2'b00) begin
      $display("FAIL undef_op: got lat=%0d req=%b fault=%b want 1/0/00", r_lat, r_req, out_fault); n_bad++; end
    consume();
  endtask

  task automatic test_timeout();
    do_op(4'd3, 32'h8000_0020, 32'h0, 0, 32'h0);
    n_cmp++; if (r_lat !== 6) begin $display("FAIL to_latency: got %0d want 6", r_lat); n_bad++; end
    n_cmp++; if (out_fault !== 2'b10 || out_memdata !== 32'h0) begin $display("FAIL to_fault: got %b/%h want 10/0", out_fault, out_memdata); n_bad++; end
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_fault !== 2'b10 || out_memdata !== 32'h0) begin
      $display("FAIL to_late_resp: got valid=%b fault=%b data=%h want 1/10/0", out_valid, out_fault, out_memdata); n_bad++; end
    consume();
    n_cmp++; if (in_ready !== 1'b1) begin $display("FAIL to_release: got %b want 1", in_ready); n_bad++; end
    do_op(4'd3, 32'h8000_0024, 32'h0, 1, 32'h1122_3344);
    n_cmp++; if (r_lat !== 3 || out_memdata !== 32'h1122_3344 || out_fault !== 2'b00) begin
      $display("FAIL to_next_op: got lat=%0d data=%h fault=%b want 3/11223344/00", r_lat, out_memdata, out_fault); n_bad++; end
    consume();
  endtask

  task automatic test_reset_mid_op();
    in_valid = 1'b1; in_op = 4'd3; in_addr = 32'h8000_0040;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1 || mem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
      $display("FAIL rst_wait_ctrl: got ready=%b req=%b valid=%b want 1/0/0", in_ready, mem_req_valid, out_valid); n_bad++; end
    n_cmp++; if (mem_req_addr !== 32'h0 || mem_req_wmask !== 4'h0 || out_fault !== 2'b00) begin
      $display("FAIL rst_wait_data: got addr=%h mask=%h fault=%b want 0/0/00", mem_req_addr, mem_req_wmask, out_fault); n_bad++; end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h9999_9999;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL rst_wait_stray_resp: got ready=%b valid=%b want 1/0", in_ready, out_valid); n_bad++; end
    do_op(4'd3, 32'h8000_0044, 32'h0, 1, 32'h0BAD_F00D);
    n_cmp++; if (r_lat !== 3 || out_memdata !== 32'h0BAD_F00D) begin
      $display("FAIL rst_wait_next: got lat=%0d data=%h want 3/0badf00d", r_lat, out_memdata); n_bad++; end
    consume();
    do_op(4'd11, 32'h8000_0048, 32'hAAAA_5555, 1, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_memdata !== 32'h0) begin
      $display("FAIL rst_done_ctrl: got valid=%b ready=%b data=%h want 0/1/0", out_valid, in_ready, out_memdata); n_bad++; end
    n_cmp++; if (mem_req_wen !== 1'b0 || mem_req_wdata !== 32'h0) begin
      $display("FAIL rst_done_req: got wen=%b wdata=%h want 0/0", mem_req_wen, mem_req_wdata); n_bad++; end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(4'd3, 32'h8000_004C, 32'h0, 1, 32'h7654_3210);
    n_cmp++; if (r_lat !== 3 || out_memdata !== 32'h7654_3210) begin
      $display("FAIL rst_done_next: got lat=%0d data=%h want 3/76543210", r_lat, out_memdata); n_bad++; end
    consume();
  endtask

  task automatic test_back_to_back();
    do_op(4'd3, 32'h8000_0050, 32'h0, 1, 32'h0102_0304);
    // new op offered during the handshake cycle must not be taken on that edge
    in_valid = 1'b1; in_op = 4'd1; in_addr = 32'h8000_0003;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
      $display("FAIL b2b_no_accept: got valid=%b ready=%b req=%b want 0/1/0", out_valid, in_ready, mem_req_valid); n_bad++; end
    do_op(4'd1, 32'h8000_0003, 32'h0, 1, 32'h7F00_0000);
    n_cmp++; if (r_lat !== 3 || out_memdata !== 32'h0000_007F) begin
      $display("FAIL b2b_second: got lat=%0d data=%h want 3/0000007f", r_lat, out_memdata); n_bad++; end
    consume();
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_op = '0; in_addr = '0; in_wdata = '0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    out_ready = 1'b0;
    test_reset();
    test_lw();
    test_byte_loads();
    test_stores();
    test_misaligned_none();
    test_timeout();
    test_reset_mid_op();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
